// File: rtl/mac8_commit_ctrl_pkg.sv
// Shared MAC8 types: accumulator width, issue-side op encoding and the pending-entry layout.
// The value helper is shared by the controller and any issue-decode logic that previews results.
package mac8_commit_ctrl_pkg;

  localparam int unsigned MAC8_ACC_W      = 32;
  localparam int unsigned MAC8_TRANS_ID_W = 3;

  typedef enum logic {
    MAC8_ACC  = 1'b0,
    MAC8_INIT = 1'b1
  } mac8_op_e;

  typedef struct packed {
    logic [MAC8_TRANS_ID_W-1:0] trans_id;
    logic [MAC8_ACC_W-1:0]      value;
  } mac8_pending_t;

  // ACC wraps modulo 2^32 by construction; there is deliberately no overflow flag.
  function automatic logic [MAC8_ACC_W-1:0] mac8_next_value(
    input mac8_op_e              op,
    input logic [MAC8_ACC_W-1:0] init_value,
    input logic [MAC8_ACC_W-1:0] spec_acc,
    input logic [MAC8_ACC_W-1:0] dot_sum
  );
    return (op == MAC8_INIT) ? init_value : (spec_acc + dot_sum);
  endfunction

endpackage

// File: rtl/mac8_pending_fifo.sv
// In-order circular buffer of speculative accumulator entries.
// Exposes head (oldest) and tail (youngest) combinationally; the count register separates full from empty.
module mac8_pending_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 35,
  parameter int unsigned TAIL_W = DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [DATA_W-1:0]          head_o,
  output logic [TAIL_W-1:0]          tail_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  import mac8_commit_ctrl_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  tail_idx;

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign tail_idx = wr_ptr_q - PTR_W'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_idx][TAIL_W-1:0];
  assign count_o  = count_q;
  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mac8_commit_ctrl.sv
// Commit-side MAC8 controller: speculative accumulator values wait in an in-order queue
// and only reach the architectural accumulator when the commit stage retires the matching tag.
module mac8_commit_ctrl
  import mac8_commit_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 4,
  parameter int unsigned TRANS_ID_W = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic                          issue_init_i,
  input  logic [TRANS_ID_W-1:0]         issue_trans_id_i,
  input  logic [31:0]                   init_value_i,
  input  logic [31:0]                   dot_sum_i,
  output logic                          result_valid_o,
  output logic [31:0]                   result_o,
  output logic [TRANS_ID_W-1:0]         result_trans_id_o,
  input  logic                          commit_i,
  input  logic [TRANS_ID_W-1:0]         commit_trans_id_i,
  output logic                          commit_error_o,
  output logic [31:0]                   arch_acc_o,
  output logic [$clog2(NR_ENTRIES):0]   pending_o
);

  localparam int unsigned ENTRY_W = TRANS_ID_W + MAC8_ACC_W;

  logic [ENTRY_W-1:0]          head_entry;
  logic [ENTRY_W-1:0]          push_entry;
  logic [MAC8_ACC_W-1:0]       tail_value;
  logic [TRANS_ID_W-1:0]       head_id;
  logic [MAC8_ACC_W-1:0]       head_value;
  logic                        fifo_empty, fifo_full;

  logic                        accept;
  logic                        commit_ok;
  logic [MAC8_ACC_W-1:0]       spec_acc;
  logic [MAC8_ACC_W-1:0]       new_value;

  logic [MAC8_ACC_W-1:0]       arch_acc_q, arch_acc_d;
  logic                        result_valid_q, result_valid_d;
  logic [MAC8_ACC_W-1:0]       result_q, result_d;
  logic [TRANS_ID_W-1:0]       result_id_q, result_id_d;
  logic                        commit_error_q, commit_error_d;

  assign head_id    = head_entry[ENTRY_W-1 -: TRANS_ID_W];
  assign head_value = head_entry[MAC8_ACC_W-1:0];
  assign push_entry = {issue_trans_id_i, new_value};

  // No same-cycle commit bypass: a full queue stalls issue even if the head retires now.
  assign issue_ready_o = !fifo_full;
  assign accept        = issue_valid_i && issue_ready_o && !flush_i;
  assign commit_ok     = commit_i && !fifo_empty && (commit_trans_id_i == head_id);

  always_comb begin
    spec_acc  = fifo_empty ? arch_acc_q : tail_value;
    new_value = mac8_next_value(mac8_op_e'(issue_init_i), init_value_i, spec_acc, dot_sum_i);

    arch_acc_d     = commit_ok ? head_value : arch_acc_q;
    commit_error_d = commit_i && !commit_ok;
    result_valid_d = accept;
    result_d       = accept ? new_value : result_q;
    result_id_d    = accept ? issue_trans_id_i : result_id_q;
  end

  mac8_pending_fifo #(
    .DEPTH  (NR_ENTRIES),
    .DATA_W (ENTRY_W),
    .TAIL_W (MAC8_ACC_W)
  ) i_pending_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .wdata_i (push_entry),
    .pop_i   (commit_ok),
    .clear_i (flush_i),
    .head_o  (head_entry),
    .tail_o  (tail_value),
    .count_o (pending_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arch_acc_q     <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_id_q    <= '0;
      commit_error_q <= 1'b0;
    end else begin
      arch_acc_q     <= arch_acc_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_id_q    <= result_id_d;
      commit_error_q <= commit_error_d;
    end
  end

  assign arch_acc_o        = arch_acc_q;
  assign result_valid_o    = result_valid_q;
  assign result_o          = result_q;
  assign result_trans_id_o = result_id_q;
  assign commit_error_o    = commit_error_q;

endmodule

// File: tb/tb_mac8_commit_ctrl.sv
// Directed bench for mac8_commit_ctrl: issued results go through a scoreboard queue checked
// by an independent monitor; commit, flush and reset effects are checked inline.
module tb_mac8_commit_ctrl;

  localparam int unsigned NR_ENTRIES = 4;
  localparam int unsigned TRANS_ID_W = 3;

  logic                          clk_i = 1'b0;
  logic                          rst_ni;
  logic                          flush_i;
  logic                          issue_valid_i;
  logic                          issue_ready_o;
  logic                          issue_init_i;
  logic [TRANS_ID_W-1:0]         issue_trans_id_i;
  logic [31:0]                   init_value_i;
  logic [31:0]                   dot_sum_i;
  logic                          result_valid_o;
  logic [31:0]                   result_o;
  logic [TRANS_ID_W-1:0]         result_trans_id_o;
  logic                          commit_i;
  logic [TRANS_ID_W-1:0]         commit_trans_id_i;
  logic                          commit_error_o;
  logic [31:0]                   arch_acc_o;
  logic [$clog2(NR_ENTRIES):0]   pending_o;

  typedef struct {
    logic [TRANS_ID_W-1:0] id;
    logic [31:0]           val;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  mac8_commit_ctrl #(
    .NR_ENTRIES (NR_ENTRIES),
    .TRANS_ID_W (TRANS_ID_W)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_init_i      (issue_init_i),
    .issue_trans_id_i  (issue_trans_id_i),
    .init_value_i      (init_value_i),
    .dot_sum_i         (dot_sum_i),
    .result_valid_o    (result_valid_o),
    .result_o          (result_o),
    .result_trans_id_o (result_trans_id_o),
    .commit_i          (commit_i),
    .commit_trans_id_i (commit_trans_id_i),
    .commit_error_o    (commit_error_o),
    .arch_acc_o        (arch_acc_o),
    .pending_o         (pending_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every writeback must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && result_valid_o) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got id %0d value 0x%08h, expected no writeback",
                 result_trans_id_o, result_o);
      end else begin
        e = sb_q.pop_front();
        $display("[TB] result id=%0d value=0x%08h (expected id=%0d value=0x%08h)",
                 result_trans_id_o, result_o, e.id, e.val);
        check("result_value", result_o, e.val);
        check("result_id", 32'(result_trans_id_o), 32'(e.id));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    commit_i      = 1'b0;
    flush_i       = 1'b0;
    tick();
  endtask

  // Leaves issue_valid_i asserted so consecutive calls issue back-to-back.
  task automatic issue(input logic is_init, input logic [TRANS_ID_W-1:0] id,
                       input logic [31:0] data, input logic [31:0] exp_val);
    int waited = 0;
    issue_valid_i    = 1'b1;
    issue_init_i     = is_init;
    issue_trans_id_i = id;
    init_value_i     = data;
    dot_sum_i        = data;
    while (!issue_ready_o && waited < 50) begin
      tick();
      waited++;
    end
    if (!issue_ready_o) begin
      tests++;
      fails++;
      $display("FAIL issue_ready_timeout: got ready 0 after %0d cycles, expected 1", waited);
    end else begin
      sb_q.push_back('{id, exp_val});
    end
    tick();
  endtask

  task automatic commit(input logic [TRANS_ID_W-1:0] id, input logic exp_err,
                        input logic [31:0] exp_arch, input int exp_pend);
    issue_valid_i     = 1'b0;
    commit_i          = 1'b1;
    commit_trans_id_i = id;
    tick();
    commit_i = 1'b0;
    $display("[TB] commit id=%0d err=%0d arch=0x%08h pending=%0d", id, commit_error_o, arch_acc_o, pending_o);
    check("commit_error", 32'(commit_error_o), 32'(exp_err));
    check("arch_acc", arch_acc_o, exp_arch);
    check("pending", 32'(pending_o), 32'(exp_pend));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni            = 1'b0;
    flush_i           = 1'b0;
    issue_valid_i     = 1'b0;
    issue_init_i      = 1'b0;
    issue_trans_id_i  = '0;
    init_value_i      = '0;
    dot_sum_i         = '0;
    commit_i          = 1'b0;
    commit_trans_id_i = '0;

    #12;
    check("reset_ready", 32'(issue_ready_o), 32'd1);
    check("reset_pending", 32'(pending_o), 32'd0);
    check("reset_arch", arch_acc_o, 32'd0);
    check("reset_result_valid", 32'(result_valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_commit_error", 32'(commit_error_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Single INIT then commit.
    issue(1'b1, 3'd1, 32'h10, 32'h10);
    commit(3'd1, 1'b0, 32'h10, 0);

    // Back-to-back chain: 0, 0+5, 5-3.
    issue(1'b1, 3'd0, 32'd0, 32'd0);
    issue(1'b0, 3'd1, 32'd5, 32'd5);
    issue(1'b0, 3'd2, 32'hFFFF_FFFD, 32'd2);
    commit(3'd0, 1'b0, 32'd0, 2);
    commit(3'd1, 1'b0, 32'd5, 1);
    commit(3'd2, 1'b0, 32'd2, 0);

    // Fill the queue from arch=2: 3, 4, 5, 6.
    issue(1'b0, 3'd0, 32'd1, 32'd3);
    issue(1'b0, 3'd1, 32'd1, 32'd4);
    issue(1'b0, 3'd2, 32'd1, 32'd5);
    issue(1'b0, 3'd3, 32'd1, 32'd6);
    check("full_ready", 32'(issue_ready_o), 32'd0);
    check("full_pending", 32'(pending_o), 32'd4);
    issue_trans_id_i = 3'd4;
    dot_sum_i        = 32'd10;
    tick();
    check("held_pending", 32'(pending_o), 32'd4);
    commit_i          = 1'b1;
    commit_trans_id_i = 3'd0;
    tick();
    commit_i = 1'b0;
    check("freed_pending", 32'(pending_o), 32'd3);
    check("freed_arch", arch_acc_o, 32'd3);
    check("freed_ready", 32'(issue_ready_o), 32'd1);
    sb_q.push_back('{3'd4, 32'd16});
    tick();
    check("held_accepted_pending", 32'(pending_o), 32'd4);
    idle();
    commit(3'd1, 1'b0, 32'd4, 3);
    commit(3'd2, 1'b0, 32'd5, 2);
    commit(3'd3, 1'b0, 32'd6, 1);
    commit(3'd4, 1'b0, 32'd16, 0);

    // Flush with a pending ACC and a colliding issue.
    issue(1'b1, 3'd5, 32'd7, 32'd7);
    commit(3'd5, 1'b0, 32'd7, 0);
    issue(1'b0, 3'd3, 32'd4, 32'd11);
    issue_trans_id_i = 3'd6;
    dot_sum_i        = 32'd100;
    flush_i          = 1'b1;
    tick();
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    $display("[TB] flush pending=%0d arch=0x%08h result_valid=%0d", pending_o, arch_acc_o, result_valid_o);
    check("flush_pending", 32'(pending_o), 32'd0);
    check("flush_arch", arch_acc_o, 32'd7);
    check("flush_result_valid", 32'(result_valid_o), 32'd0);
    issue(1'b0, 3'd7, 32'd1, 32'd8);
    commit(3'd7, 1'b0, 32'd8, 0);

    // Bad commits: tag mismatch, then empty queue.
    issue(1'b1, 3'd4, 32'h55, 32'h55);
    commit(3'd5, 1'b1, 32'd8, 1);
    idle();
    check("error_pulse_clear", 32'(commit_error_o), 32'd0);
    commit(3'd4, 1'b0, 32'h55, 0);
    commit(3'd4, 1'b1, 32'h55, 0);

    // Wrap-around and asynchronous reset with entries in flight.
    issue(1'b1, 3'd1, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
    commit(3'd1, 1'b0, 32'hFFFF_FFF0, 0);
    issue(1'b0, 3'd2, 32'h20, 32'h10);
    issue(1'b0, 3'd3, 32'd1, 32'h11);
    idle();
    check("pre_reset_pending", 32'(pending_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    $display("[TB] async reset arch=0x%08h pending=%0d result=0x%08h", arch_acc_o, pending_o, result_o);
    check("areset_arch", arch_acc_o, 32'd0);
    check("areset_pending", 32'(pending_o), 32'd0);
    check("areset_result_valid", 32'(result_valid_o), 32'd0);
    check("areset_result", result_o, 32'd0);
    check("areset_result_id", 32'(result_trans_id_o), 32'd0);
    check("areset_commit_error", 32'(commit_error_o), 32'd0);
    check("areset_ready", 32'(issue_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check("post_reset_arch", arch_acc_o, 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
